// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end for a small multi-cycle CPU. It holds the
// program counter and the instruction register (IR). On request from the
// control unit it fetches the word at pc over a single-outstanding memory
// handshake. While that fetch is pending it raises fetch_busy, and the
// control unit holds its state until fetch_busy drops.
//
// Optional feature (macro FETCH_PREFETCH_EN):
//   Adds a one-entry prefetch buffer (data, tag, valid). After every IR load,
//   the block fetches (load address + 1) in the background. A later ir_write
//   whose pc matches the buffered tag then completes with no wait.
//   With the macro undefined, every ir_write is a plain demand fetch.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   ir_write     load the instruction at the current pc into IR
//   pc_write     update pc this cycle
//   pc_src       0: pc <= pc + 1 (mod 32), 1: pc <= IR[4:0]
//   imem_req     instruction memory read request (held until acknowledged)
//   imem_addr    instruction memory read address (held with imem_req)
//   imem_ack     single-cycle acknowledge, imem_rdata valid in same cycle
//   imem_rdata   instruction word returned by memory
//   instruction  current IR contents
//   pc           current program counter
//   fetch_busy   high exactly while a demand fetch is outstanding
// ---------------------------------------------------------------------------
module fetch_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_write,
  input  logic       pc_write,
  input  logic       pc_src,
  output logic       imem_req,
  output logic [4:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic [7:0] instruction,
  output logic [4:0] pc,
  output logic       fetch_busy
);

`ifdef FETCH_PREFETCH_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request outstanding
    WAIT_IR = 2'd1,  // demand fetch outstanding, control unit stalled
    PREF    = 2'd2   // background prefetch outstanding
  } state_e;
`else
  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_IR = 1'b1
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [4:0] pc_q,    pc_d;
  logic [7:0] ir_q,    ir_d;
  logic       req_q,   req_d;
  logic [4:0] addr_q,  addr_d;
  logic       busy_q,  busy_d;

`ifdef FETCH_PREFETCH_EN
  logic       buf_valid_q, buf_valid_d;
  logic [4:0] buf_tag_q,   buf_tag_d;
  logic [7:0] buf_data_q,  buf_data_d;
  // The in-flight response is stale and must be discarded. After it lands,
  // the demand fetch for dem_addr_q is issued.
  logic       drop_q,      drop_d;
  logic [4:0] dem_addr_q,  dem_addr_d;
  logic       buf_hit;

  assign buf_hit = buf_valid_q && (buf_tag_q == pc_q);
`endif

  // The pc update does not depend on the fetch state. A jump uses the IR
  // value from before any IR load on the same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    pc_d = pc_q;
    if (pc_write) begin
      pc_d = pc_src ? ir_q[4:0] : pc_q + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    req_d   = req_q;
    addr_d  = addr_q;
`ifdef FETCH_PREFETCH_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    drop_d      = drop_q;
    dem_addr_d  = dem_addr_q;
    // After a jump the buffered word is unlikely to be wanted.
    if (pc_write && pc_src) begin
      buf_valid_d = 1'b0;
    end
`endif

    case (state_q)
      IDLE: begin
`ifdef FETCH_PREFETCH_EN
        if (ir_write && buf_hit) begin
          ir_d        = buf_data_q;
          buf_valid_d = 1'b0;
          state_d     = PREF;
          req_d       = 1'b1;
          addr_d      = pc_q + 5'd1;
        end else
`endif
        if (ir_write) begin
          // The fetch address is the pc from before any same-edge pc update.
          state_d = WAIT_IR;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end

      WAIT_IR: begin
        if (imem_ack) begin
`ifdef FETCH_PREFETCH_EN
          if (drop_q) begin
            // Stale prefetch data is dropped. The demand request follows
            // immediately as a new transaction, still in WAIT_IR.
            drop_d = 1'b0;
            addr_d = dem_addr_q;
          end else begin
            ir_d    = imem_rdata;
            state_d = PREF;
            addr_d  = addr_q + 5'd1;
          end
`else
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          state_d = IDLE;
`endif
        end
      end

`ifdef FETCH_PREFETCH_EN
      PREF: begin
        if (imem_ack) begin
          if (ir_write && (addr_q == pc_q)) begin
            // The prefetched word is the one wanted right now.
            ir_d   = imem_rdata;
            addr_d = addr_q + 5'd1;
          end else if (ir_write) begin
            state_d = WAIT_IR;
            addr_d  = pc_q;
          end else begin
            buf_data_d  = imem_rdata;
            buf_tag_d   = addr_q;
            buf_valid_d = 1'b1;
            req_d       = 1'b0;
            state_d     = IDLE;
          end
        end else if (ir_write) begin
          // A matching prefetch becomes the demand fetch. A wrong-address
          // prefetch must finish first, so the handshake stays intact.
          state_d = WAIT_IR;
          if (addr_q != pc_q) begin
            drop_d     = 1'b1;
            dem_addr_d = pc_q;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_IR);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= 5'd0;
      ir_q        <= 8'h00;
      req_q       <= 1'b0;
      addr_q      <= 5'd0;
      busy_q      <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      dem_addr_q  <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
`ifdef FETCH_PREFETCH_EN
      buf_valid_q <= buf_valid_d;
      drop_q      <= drop_d;
      dem_addr_q  <= dem_addr_d;
`endif
    end
  end

`ifdef FETCH_PREFETCH_EN
  // NOTE: buffer payload is only read when buf_valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_tag_q  <= buf_tag_d;
  end
`endif

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = ir_q;
  assign pc          = pc_q;
  assign fetch_busy  = busy_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ir_write  input  1  control unit: load the instruction at current pc into IR.
REQ-004 pc_write  input  1  control unit: update pc this cycle.
REQ-005 pc_src  input  1  0 = sequential (pc+1), 1 = jump to instruction[4:0].
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  5  instruction memory read address.
REQ-008 imem_ack  input  1  single-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  8  instruction word from memory.
REQ-010 instruction  output  8  IR contents, driven to the control unit.
REQ-011 pc  output  5  program counter, driven to the control unit.
REQ-012 fetch_busy  output  1  IR load pending; the control unit SHALL hold its state while this is high.

Function
REQ-013 FSM states: IDLE (no request outstanding), WAIT_IR (demand fetch outstanding), PREF (prefetch outstanding; only with FETCH_PREFETCH_EN).
REQ-014 IDLE with ir_write=1 and no buffer hit -> assert imem_req with imem_addr=pc next cycle, enter WAIT_IR.
REQ-015 WAIT_IR with imem_ack=1 -> IR<=imem_rdata at that edge, deassert imem_req, enter IDLE (or PREF, per REQ-025).
REQ-016 fetch_busy = 1 exactly while in WAIT_IR; miss latency is one request cycle plus memory wait, minimum 2 cycles from ir_write to IR valid.
REQ-017 Handshake: imem_req and imem_addr held stable until imem_ack is sampled high; at most one outstanding request; imem_ack while imem_req=0 ignored.
REQ-018 pc_write=1, pc_src=0 -> pc <= pc+1 modulo 32 (pc 31 wraps to 0).
REQ-019 pc_write=1, pc_src=1 -> pc <= instruction[4:0] (IR value before any same-edge load).
REQ-020 Simultaneous ir_write and pc_write: the fetch uses the pre-update pc; pc updates on the same edge.
REQ-021 ir_write or pc_write arriving in WAIT_IR: ir_write ignored; pc_write applied normally, the outstanding demand request is unaffected.

Reset
REQ-022 reset=1 at an edge: pc=0, instruction=8'h00 (NOP), imem_req=0, imem_addr=0, fetch_busy=0, state=IDLE, prefetch buffer invalid.
REQ-023 Reset mid-request abandons the request; an imem_ack arriving after reset is ignored and no state changes from it.

Configuration
REQ-024 Macro FETCH_PREFETCH_EN selects a one-entry prefetch buffer (8-bit data, 5-bit tag, valid bit).
REQ-025 Defined: after every IR load, issue a request for (load address+1) mod 32 in PREF; on ack, store data/tag and set valid.
REQ-026 Defined: ir_write in IDLE with valid and tag==pc -> IR<=buffer on that edge, fetch_busy stays 0, valid cleared, next prefetch issued.
REQ-027 Defined: ir_write during PREF with matching tag promotes the request to WAIT_IR (fetch_busy=1); a non-matching tag lets the prefetch complete, discards its data, then issues a demand fetch.
REQ-028 Defined: pc_write with pc_src=1 clears the buffer valid bit.
REQ-029 Undefined: no buffer, no PREF state; every ir_write is a demand fetch per REQ-014.

Verification
REQ-030 Reset, then ir_write pulse at pc=0 with mem[0]=8'h0A acked 1 cycle after req -> imem_addr=0, fetch_busy high 2 cycles, instruction=8'h0A.
REQ-031 pc=31, pc_write=1, pc_src=0 -> pc=0; then IR=8'hE5, pc_write=1, pc_src=1 -> pc=5'h05.
REQ-032 Ack delayed 4 cycles -> imem_req and imem_addr stable throughout, fetch_busy high until the ack edge, spurious ack with req=0 leaves IR unchanged.
REQ-033 Reset asserted during WAIT_IR, ack arrives next cycle -> pc=0, instruction=8'h00, imem_req=0, fetch_busy=0.
REQ-034 FETCH_PREFETCH_EN: sequential fetch of pc=2 then pc=3 with mem[3]=8'h64 prefetched -> second ir_write loads 8'h64 with fetch_busy never asserting.
REQ-035 FETCH_PREFETCH_EN: jump to pc=5'h10 while a prefetch for pc=4 is outstanding -> stale data discarded, demand fetch imem_addr=5'h10, IR=mem[16].
